// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and widths for the stopwatch control slice
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    STOPPED = 2'd2,
    LAP     = 2'd3
  } sw_state_t;

  localparam int DIGITS_W = 16;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - 2-FF synchroniser plus counter debounce with a one-cycle press pulse
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic stable,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // press is raised on the same edge that accepts a 0->1 change, so it lines up with stable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync2;
        cnt    <= '0;
        press  <= sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - start/stop/lap/clear control FSM with lap-frozen digit display path
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                btn_start,
  input  logic                btn_lap,
  input  logic [DIGITS_W-1:0] digits_in,
  output logic                run,
  output logic                clear,
  output logic                lap_active,
  output logic [DIGITS_W-1:0] digits_out
);

  sw_state_t state;
  sw_state_t state_next;
  logic      start_press;
  logic      lap_press;
  logic      start_stable;
  logic      lap_stable;
  logic      unused_stable;
  logic      run_next;
  logic      clear_next;
  logic      lap_next;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_raw (btn_start),
    .stable  (start_stable),
    .press   (start_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap_db (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_raw (btn_lap),
    .stable  (lap_stable),
    .press   (lap_press)
  );

  assign unused_stable = start_stable ^ lap_stable;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // start is tested first in every state, so a simultaneous lap press is dropped
  always_comb begin
    state_next = state;
    clear_next = 1'b0;
    case (state)
      IDLE: begin
        if (start_press) state_next = RUNNING;
      end
      RUNNING: begin
        if (start_press)    state_next = STOPPED;
        else if (lap_press) state_next = LAP;
      end
      LAP: begin
        if (start_press)    state_next = STOPPED;
        else if (lap_press) state_next = RUNNING;
      end
      STOPPED: begin
        if (start_press) begin
          state_next = RUNNING;
        end else if (lap_press) begin
          state_next = IDLE;
          clear_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    run_next = (state_next == RUNNING) || (state_next == LAP);
    lap_next = (state_next == LAP);
  end

  // digits keep tracking on the edge that enters LAP, which is the capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run        <= 1'b0;
      clear      <= 1'b0;
      lap_active <= 1'b0;
      digits_out <= '0;
    end else begin
      run        <= run_next;
      clear      <= clear_next;
      lap_active <= lap_next;
      if (state != LAP) digits_out <= digits_in;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        btn_start;
  logic        btn_lap;
  logic [15:0] digits_in;
  logic        run;
  logic        clear;
  logic        lap_active;
  logic [15:0] digits_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_start  (btn_start),
    .btn_lap    (btn_lap),
    .digits_in  (digits_in),
    .run        (run),
    .clear      (clear),
    .lap_active (lap_active),
    .digits_out (digits_out)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // hold the raw buttons long enough for one press, then release and let the release settle
  task automatic press(input logic s, input logic l);
    btn_start = s;
    btn_lap   = l;
    step(8);
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    step(8);
  endtask

  initial begin
    int presses;
    int clears;

    reset_n   = 1'b0;
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    digits_in = 16'h0000;
    step(2);
    check("rst_run", 32'(run), 32'd0);
    check("rst_clear", 32'(clear), 32'd0);
    check("rst_lap_active", 32'(lap_active), 32'd0);
    check("rst_digits", 32'(digits_out), 32'h0);
    reset_n = 1'b1;
    step(1);

    // 1: held start -> press at cycle 7, run at cycle 8
    btn_start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      check($sformatf("t1_press_c%0d", k), 32'(dut.u_start_db.press), 32'(k == 7));
      check($sformatf("t1_run_c%0d", k), 32'(run), 32'(k >= 8));
      check($sformatf("t1_clear_c%0d", k), 32'(clear), 32'd0);
    end
    btn_start = 1'b0;
    step(8);

    // 2: bouncing start never settles
    presses = 0;
    for (int i = 0; i < 30; i++) begin
      btn_start = (i < 20) && ((i / 2) % 2 == 0);
      step(1);
      if (dut.u_start_db.press) presses++;
    end
    check("t2_presses", 32'(presses), 32'd0);
    check("t2_run", 32'(run), 32'd1);

    // 3: lap capture and hold, second lap resumes tracking
    digits_in = 16'h0050;
    step(1);
    check("t3_track", 32'(digits_out), 32'h0050);
    btn_lap   = 1'b1;
    digits_in = 16'h0123;
    step(7);
    check("t3_lap_press", 32'(dut.u_lap_db.press), 32'd1);
    check("t3_pre_lap_active", 32'(lap_active), 32'd0);
    step(1);
    check("t3_lap_active", 32'(lap_active), 32'd1);
    check("t3_run", 32'(run), 32'd1);
    check("t3_capture", 32'(digits_out), 32'h0123);
    btn_lap = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      digits_in = 16'h0123 + 16'(i);
      step(1);
      check($sformatf("t3_hold_%0d", i), 32'(digits_out), 32'h0123);
    end
    btn_lap = 1'b1;
    step(8);
    check("t3_unlap_active", 32'(lap_active), 32'd0);
    check("t3_unlap_hold", 32'(digits_out), 32'h0123);
    digits_in = 16'h0999;
    step(1);
    check("t3_resume", 32'(digits_out), 32'h0999);
    btn_lap = 1'b0;
    step(8);

    // 4: stop, then lap clears once and returns to idle
    press(1'b1, 1'b0);
    check("t4_stopped_run", 32'(run), 32'd0);
    btn_lap = 1'b1;
    step(7);
    check("t4_clear_early", 32'(clear), 32'd0);
    step(1);
    check("t4_clear_hi", 32'(clear), 32'd1);
    check("t4_run", 32'(run), 32'd0);
    step(1);
    check("t4_clear_lo", 32'(clear), 32'd0);
    btn_lap = 1'b0;
    step(8);
    clears = 0;
    btn_lap = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) btn_lap = 1'b0;
      step(1);
      if (clear) clears++;
    end
    check("t4_no_clear_idle", 32'(clears), 32'd0);
    check("t4_idle_run", 32'(run), 32'd0);

    // 5: simultaneous start and lap while running
    press(1'b1, 1'b0);
    check("t5_running", 32'(run), 32'd1);
    btn_start = 1'b1;
    btn_lap   = 1'b1;
    step(8);
    check("t5_run", 32'(run), 32'd0);
    check("t5_lap_active", 32'(lap_active), 32'd0);
    digits_in = 16'h0777;
    step(1);
    check("t5_no_capture", 32'(digits_out), 32'h0777);
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    step(8);

    // 6: async reset in LAP mid-debounce, held button presses once after release
    press(1'b1, 1'b0);
    digits_in = 16'h0456;
    press(1'b0, 1'b1);
    check("t6_in_lap", 32'(lap_active), 32'd1);
    check("t6_lap_digits", 32'(digits_out), 32'h0456);
    digits_in = 16'h0457;
    btn_start = 1'b1;
    step(4);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_run", 32'(run), 32'd0);
    check("t6_async_lap_active", 32'(lap_active), 32'd0);
    check("t6_async_digits", 32'(digits_out), 32'h0);
    check("t6_async_clear", 32'(clear), 32'd0);
    step(2);
    check("t6_rst_held_run", 32'(run), 32'd0);
    reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      check($sformatf("t6_press_c%0d", k), 32'(dut.u_start_db.press), 32'(k == 7));
      check($sformatf("t6_run_c%0d", k), 32'(run), 32'(k >= 8));
    end
    btn_start = 1'b0;
    step(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
